// File: rtl/player_press_conditioner.sv
// ============================================================================
// player_press_conditioner
//
// Turns the two synchronized, active-low player key levels of the tug-of-war
// game into debounced, single-cycle move pulses. It sits between the input
// synchronizers and the light chain. Each player has its own debounce FSM and
// stability counter. The FSM guarantees:
//   - exactly one pulse per physical press;
//   - no pulse from contact bounce;
//   - no pulse from a key that was held down through reset.
//
// Optional build macro:
//   PRESS_TIE_CANCEL_EN - when defined, a press completed by both players at
//                         the same edge produces no pulse at all. When not
//                         defined (the default), both pulses assert together
//                         and the light cells resolve the tie.
//
// Parameters:
//   DEBOUNCE_CYCLES - a level change is accepted after DEBOUNCE_CYCLES+1
//                     consecutive equal samples (1 .. 2^CNT_W-1)
//   CNT_W           - width of each per-channel stability counter
//
// Ports:
//   clk     in   system clock (CLOCK_50 domain)
//   reset   in   asynchronous, active-high, clears all state
//   key_l_n in   left key, synchronized, 0 = pressed
//   key_r_n in   right key, synchronized, 0 = pressed
//   enable  in   game running; 0 while a winner is displayed
//   L       out  one-cycle left move pulse, registered
//   R       out  one-cycle right move pulse, registered
//   l_held  out  debounced left pressed level
//   r_held  out  debounced right pressed level
// ============================================================================
module player_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic enable,
    output logic L,
    output logic R,
    output logic l_held,
    output logic r_held
);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } chan_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel 0 is the left player and channel 1 is the right player.
    chan_state_t      state_q [2];
    chan_state_t      state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       pressed;
    logic [1:0]       cand;
    logic             pulse_l;
    logic             pulse_r;

    assign pressed = {~key_r_n, ~key_l_n};

    // State and counter registers for both channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= ARM;
                cnt_q[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Next-state logic, shared by both channels.
    // ARM only leaves after a full run of released samples, so a key held
    // through reset has to be let go before its next press can count.
    // A candidate pulse exists only on the PRESS_WAIT -> PRESSED edge.
    // A glitch during RELEASE_WAIT therefore returns to PRESSED silently.
    // The counter stops at CNT_MAX because every branch that reaches it
    // either changes state or leaves it unchanged.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            cand[ch]    = 1'b0;
            case (state_q[ch])
                ARM: begin
                    if (pressed[ch]) begin
                        cnt_d[ch] = '0;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (pressed[ch]) begin
                        state_d[ch] = PRESS_WAIT;
                        cnt_d[ch]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = PRESSED;
                        cand[ch]    = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!pressed[ch]) begin
                        state_d[ch] = RELEASE_WAIT;
                        cnt_d[ch]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed[ch]) begin
                        state_d[ch] = PRESSED;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[ch] = ARM;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    // Gate candidates with enable and resolve ties.
    // A press that completes while the game is disabled is dropped, not held
    // back: the FSM is already in PRESSED, so no later candidate appears
    // until the key is released and pressed again.
    always_comb begin
        pulse_l = cand[0] & enable;
        pulse_r = cand[1] & enable;
`ifdef PRESS_TIE_CANCEL_EN
        if (cand[0] && cand[1]) begin
            pulse_l = 1'b0;
            pulse_r = 1'b0;
        end
`endif
    end

    // Registered move pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= pulse_l;
            R <= pulse_r;
        end
    end

    assign l_held = (state_q[0] == PRESSED) || (state_q[0] == RELEASE_WAIT);
    assign r_held = (state_q[1] == PRESSED) || (state_q[1] == RELEASE_WAIT);

endmodule

// File: tb/tb_player_press_conditioner.sv
// ============================================================================
// tb_player_press_conditioner
//
// Directed testbench for player_press_conditioner with DEBOUNCE_CYCLES = 3.
// All expectations are written as {L, R, l_held, r_held}.
// ============================================================================
module tb_player_press_conditioner;

    logic clk;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic enable;
    logic L;
    logic R;
    logic l_held;
    logic r_held;

    int checks;
    int errors;

`ifdef PRESS_TIE_CANCEL_EN
    localparam logic [3:0] TIE_EXP = 4'b0011;
`else
    localparam logic [3:0] TIE_EXP = 4'b1111;
`endif

    player_press_conditioner #(
        .DEBOUNCE_CYCLES(3),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .enable(enable),
        .L(L),
        .R(R),
        .l_held(l_held),
        .r_held(r_held)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample: the next rising edge captures it, and outputs are
    // then observed 1 ns after that edge
    task automatic applyStimulus(input logic kl, input logic kr, input logic en);
        key_l_n = kl;
        key_r_n = kr;
        enable  = en;
        @(posedge clk);
        #1;
    endtask

    // Compare {L, R, l_held, r_held} against a hand-computed value
    task automatic checkOutput(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {L, R, l_held, r_held};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        key_l_n = 1'b1;
        key_r_n = 1'b0;
        enable  = 1'b1;
        #3;
        checkOutput("reset_state", 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] right key held through reset");

        // Right key held through reset: it must never pulse
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("held_through_reset", 4'b0000);
        end
        // Released for 4 samples: ARM completes on the 4th
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("arm_release", 4'b0000);
        end
        // Press for 4 samples: pulse after the 4th
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("r_press_wait", 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("r_pulse", 4'b0101);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("r_pulse_single", 4'b0001);
        // Release latency: held falls after 4 released samples
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("r_release_wait", 4'b0001);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("r_released", 4'b0000);

        $display("[TB] bounce on left key");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("bounce_short_run", 4'b0000);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("bounce_gap", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("bounce_second_run", 4'b0000);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("bounce_l_pulse", 4'b1010);

        $display("[TB] long hold with glitch");
        // A 2-sample release glitch must not drop held or re-pulse
        for (int i = 0; i < 50; i++) begin
            applyStimulus((i == 20 || i == 21) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            checkOutput("long_hold", 4'b0010);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("l_release_wait", 4'b0010);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("l_released", 4'b0000);

        $display("[TB] simultaneous presses");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("tie_wait", 4'b0000);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("tie_result", TIE_EXP);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("tie_after", 4'b0011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("tie_release_wait", 4'b0011);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("tie_released", 4'b0000);

        // Right press starts one edge after left: two separate pulses
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stagger_1", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stagger_2", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stagger_3", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stagger_l_pulse", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stagger_r_pulse", 4'b0111);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stagger_after", 4'b0011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("stagger_release_wait", 4'b0011);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("stagger_released", 4'b0000);

        $display("[TB] press completed while disabled");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("dis_wait", 4'b0000);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("dis_no_pulse", 4'b0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("reenable_no_pulse", 4'b0010);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("dis_release_wait", 4'b0010);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("dis_released", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("repress_wait", 4'b0000);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("repress_pulse", 4'b1010);

        $display("[TB] asynchronous reset");
        // Left stays PRESSED and right is mid PRESS_WAIT
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_1", 4'b0010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_2", 4'b0010);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_wait", 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Keys still down after reset: back in ARM, so nothing may pulse
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("rearm_held", 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("rearm_release", 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("rearm_r_wait", 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("rearm_r_pulse", 4'b0101);
        // Reset during the R pulse cycle
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_pulse", 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // The right key is still held, so ARM must block it again
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("post_reset_held", 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("post_reset_release", 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("post_reset_r_wait", 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("post_reset_r_pulse", 4'b0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_press_conditioner.md
# player_press_conditioner

Converts the two synchronized, active-low player push-button levels of the tug-of-war game into debounced single-cycle move pulses `L` and `R`. These pulses drive every playfield light cell. It sits between the two-flop input synchronizers and the light chain. It guarantees exactly one pulse per physical press, no pulse from bounce or from a key held through reset, and a defined outcome when both players press in the same cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 16: a level change is accepted after it is sampled on DEBOUNCE_CYCLES+1 consecutive edges; legal range 1 .. 2^CNT_W−1.
- `CNT_W`, default 5: width of each per-channel stability counter.
- `clk`  in  1: system clock (CLOCK_50 domain); one clock only.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `key_l_n`  in  1: left player key, synchronized, 0 = pressed.
- `key_r_n`  in  1: right player key, synchronized, 0 = pressed.
- `enable`  in  1: game running; 0 while a winner is displayed.
- `L`  out  1: one-cycle left move pulse, registered.
- `R`  out  1: one-cycle right move pulse, registered.
- `l_held`  out  1: debounced left pressed level.
- `r_held`  out  1: debounced right pressed level.

## Operation
- Two identical channel FSMs, each with its own counter `cnt`. States are ARM, IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
- ARM (reset state, cnt=0):
  - released sample: cnt+1; at cnt==DEBOUNCE_CYCLES with another released sample, go to IDLE.
  - pressed sample: cnt=0.
  - Purpose: a key held through reset never generates a pulse.
- IDLE: pressed sample → PRESS_WAIT with cnt=1.
- PRESS_WAIT:
  - released sample → IDLE, cnt=0.
  - pressed sample with cnt<DEBOUNCE_CYCLES → cnt+1.
  - pressed sample with cnt==DEBOUNCE_CYCLES → PRESSED; raise the channel's candidate pulse.
- PRESSED: released sample → RELEASE_WAIT with cnt=1.
- RELEASE_WAIT:
  - pressed sample → PRESSED, with no new candidate.
  - released sample with cnt<DEBOUNCE_CYCLES → cnt+1.
  - released sample with cnt==DEBOUNCE_CYCLES → IDLE.
- cnt saturates at DEBOUNCE_CYCLES and never wraps.
- `l_held`/`r_held` = state ∈ {PRESSED, RELEASE_WAIT}. ARM reports 0.
- A candidate exists only on the edge entering PRESSED from PRESS_WAIT. Holding a key indefinitely yields exactly one pulse.
- Output pulse is `cand & enable` for each channel, then tie resolution (see Configuration). FSMs keep tracking while `enable`=0. A press completed while disabled is discarded, not deferred.

## Timing
- Reset values: `L`=0, `R`=0, `l_held`=0, `r_held`=0. Both FSMs in ARM, cnt=0. Outputs go 0 asynchronously on reset assertion, including mid-pulse or mid-count.
- Press latency: with first pressed sample at edge e0 and all samples pressed, `L`/`R` is 1 for exactly the cycle following edge e(DEBOUNCE_CYCLES). `held` rises at the same edge.
- Release latency: `held` falls at the edge after DEBOUNCE_CYCLES+1 consecutive released samples.
- After reset deassertion, a key must be released for DEBOUNCE_CYCLES+1 samples before a press can count.
- `enable` is sampled at the same edge that registers the pulse.
- Both candidates at the same edge form a tie. Candidates one edge apart are not a tie: both pulse, in their own cycles.
- `L` and `R` are never high for two consecutive cycles.

## Configuration
- `PRESS_TIE_CANCEL_EN` defined:
  - On a tie, neither `L` nor `R` asserts; the rope does not move.
  - Both FSMs still enter PRESSED, so the `held` outputs are 1.
- `PRESS_TIE_CANCEL_EN` not defined: on a tie, `L` and `R` both assert in the same cycle, and the light cells resolve it.

## Test plan
Bench uses DEBOUNCE_CYCLES=3.
- Reset with `key_r_n`=0, deassert reset, hold 20 cycles → `R` stays 0 and `r_held` stays 0. Release for 4 cycles, then press for 4 → single one-cycle `R` pulse in the cycle after the 4th pressed sample; `r_held`=1.
- Bounce: `key_l_n` low 3 samples, high 1, low 4 → no pulse from the first run; one `L` pulse after the 4th sample of the second run.
- Hold `key_l_n` low 50 cycles with a 2-sample high glitch at cycle 20 → exactly one `L` pulse total; `l_held` stays 1 throughout.
- Both keys low at the same edge for 4 samples → with `PRESS_TIE_CANCEL_EN`, `L`=`R`=0 and both `held`=1; without it, `L`=`R`=1 in the same cycle. Right key delayed one cycle → `L` then `R` pulse on consecutive cycles.
- `enable`=0 while a left press completes, then `enable`=1 with the key still held → no `L` pulse. Release and re-press → `L` pulses.
- Assert `reset` mid-PRESS_WAIT and again during an `R` pulse cycle → all outputs 0 before the next clock edge; the FSM restarts in ARM.
